// File: rtl/c8_ctrl_pkg.sv
// Shared types and default widths for the c8 sequence controller.
// Holds the command opcodes, the controller states and the datapath action encoding.
package c8_ctrl_pkg;

  localparam int C8_WIDTH  = 8;
  localparam int C8_STEP_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD_A = 2'b00,
    OP_LOAD_B = 2'b01,
    OP_COUNT  = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // One action per cycle is applied to the counter register.
  typedef enum logic [2:0] {
    DP_HOLD   = 3'd0,
    DP_LOAD_A = 3'd1,
    DP_LOAD_B = 3'd2,
    DP_CLEAR  = 3'd3,
    DP_INC    = 3'd4
  } dp_op_e;

endpackage

// File: rtl/c8_cnt_dp.sv
// Counter datapath: source mux, incrementer, counter register and registered wrap pulse.
// Result visible one cycle after the action; no backpressure, an action is applied every cycle.
module c8_cnt_dp
  import c8_ctrl_pkg::*;
#(
  parameter int WIDTH = C8_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  dp_op_e           op_i,
  input  logic [WIDTH-1:0] a_dat_i,
  input  logic [WIDTH-1:0] b_dat_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    case (op_i)
      DP_LOAD_A: cnt_d = a_dat_i;
      DP_LOAD_B: cnt_d = b_dat_i;
      DP_CLEAR:  cnt_d = '0;
      DP_INC: begin
        cnt_d  = cnt_q + 1'b1;
        // Only an increment out of all-ones wraps; loads landing on zero do not.
        wrap_d = &cnt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/c8_seq_ctrl.sv
// Command sequencer: LOAD_A/LOAD_B/CLEAR/COUNT driving a wrapping counter, one-cycle DONE pulse.
// Loads finish 1 cycle after accept, COUNT N after N+1 (+halt cycles); commands wait while not IDLE.
module c8_seq_ctrl
  import c8_ctrl_pkg::*;
#(
  parameter int WIDTH  = C8_WIDTH,
  parameter int STEP_W = C8_STEP_W
) (
  input  logic              clk_pad,
  input  logic              rst_n_pad,
  input  logic              cmd_valid_pad,
  output logic              cmd_ready_pad,
  input  logic [1:0]        cmd_op_pad,
  input  logic [STEP_W-1:0] cmd_arg_pad,
  input  logic [WIDTH-1:0]  a_data_pad,
  input  logic [WIDTH-1:0]  b_data_pad,
  input  logic              halt_pad,
  output logic [WIDTH-1:0]  cnt_pad,
  output logic              busy_pad,
  output logic              done_pad,
  output logic              wrap_pad
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  dp_op_e            dp_op;
  op_e               op;
  logic              accept;

  assign op = op_e'(cmd_op_pad);

  // Reset gates ready so nothing is accepted while the block is held in reset.
  assign cmd_ready_pad = (state_q == ST_IDLE) & rst_n_pad;
  assign accept        = cmd_valid_pad & cmd_ready_pad;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dp_op   = DP_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DONE;
          case (op)
            OP_LOAD_A: dp_op = DP_LOAD_A;
            OP_LOAD_B: dp_op = DP_LOAD_B;
            OP_CLEAR:  dp_op = DP_CLEAR;
            OP_COUNT: begin
              if (cmd_arg_pad != '0) begin
                rem_d   = cmd_arg_pad;
                state_d = ST_COUNT;
              end
            end
            default: ;
          endcase
        end
      end
      ST_COUNT: begin
        if (!halt_pad) begin
          dp_op = DP_INC;
          rem_d = rem_q - 1'b1;
          if (rem_q == STEP_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  c8_cnt_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk_i   (clk_pad),
    .rst_n_i (rst_n_pad),
    .op_i    (dp_op),
    .a_dat_i (a_data_pad),
    .b_dat_i (b_data_pad),
    .cnt_o   (cnt_pad),
    .wrap_o  (wrap_pad)
  );

  assign busy_pad = (state_q != ST_IDLE);
  assign done_pad = (state_q == ST_DONE);

endmodule

// File: doc/c8_seq_ctrl.md
C8_SEQ_CTRL -- requirements
Module: c8_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and data width.
REQ-002 SHALL have parameter STEP_W, default 8, width of the COUNT step argument.
REQ-003 SHALL have port clk_pad, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_pad, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid_pad, input, 1, command offered.
REQ-006 SHALL have port cmd_ready_pad, output, 1, command accepted this cycle when high with cmd_valid_pad.
REQ-007 SHALL have port cmd_op_pad, input, 2, opcode: 00 LOAD_A, 01 LOAD_B, 10 COUNT, 11 CLEAR.
REQ-008 SHALL have port cmd_arg_pad, input, STEP_W, number of increments for COUNT; ignored otherwise.
REQ-009 SHALL have port a_data_pad, input, WIDTH, load source A.
REQ-010 SHALL have port b_data_pad, input, WIDTH, load source B.
REQ-011 SHALL have port halt_pad, input, 1, pauses counting while high.
REQ-012 SHALL have port cnt_pad, output, WIDTH, registered counter value.
REQ-013 SHALL have port busy_pad, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port done_pad, output, 1, one-cycle pulse at command completion.
REQ-015 SHALL have port wrap_pad, output, 1, one-cycle pulse when an increment wraps all-ones to zero.

Function
REQ-016 SHALL implement states IDLE, COUNT, DONE.
REQ-017 SHALL drive cmd_ready_pad high only in IDLE; accept = cmd_valid_pad & cmd_ready_pad.
REQ-018 SHALL, on accept of LOAD_A, LOAD_B or CLEAR, update cnt_pad at the accepting edge (to a_data_pad, b_data_pad, or zero, sampled that cycle) and enter DONE.
REQ-019 SHALL, on accept of COUNT with cmd_arg_pad = 0, leave cnt_pad unchanged and enter DONE.
REQ-020 SHALL, on accept of COUNT with cmd_arg_pad = N > 0, latch N into a remaining-steps register and enter COUNT.
REQ-021 SHALL, in COUNT with halt_pad low, increment cnt_pad modulo 2^WIDTH and decrement remaining each cycle; on the edge where remaining goes 1 -> 0, enter DONE.
REQ-022 SHALL, in COUNT with halt_pad high, hold cnt_pad, remaining and state unchanged.
REQ-023 SHALL assert wrap_pad (registered) in the cycle after an increment from all-ones to zero; never on loads or CLEAR.
REQ-024 SHALL hold DONE for exactly one cycle with done_pad = 1, then return to IDLE; done_pad = 0 in all other states.
REQ-025 SHALL ignore cmd_valid_pad outside IDLE; a held command is accepted on the first IDLE cycle.
REQ-026 SHALL give COUNT of N steps, without halt, done_pad exactly N+1 cycles after the accepting edge; loads/CLEAR/N=0 give done_pad 1 cycle after.
REQ-027 SHALL hold cnt_pad between commands.

Reset
REQ-028 SHALL, while rst_n_pad is low, force state IDLE, cnt_pad 0, remaining 0, done_pad 0, wrap_pad 0, busy_pad 0; cmd_ready_pad is 0 during reset.
REQ-029 SHALL abort any command in progress on reset assertion, with no done_pad pulse.
REQ-030 SHALL accept a command no earlier than the first rising edge after rst_n_pad deasserts.

Structure
REQ-031 SHALL place the opcode enum, the state enum and default WIDTH/STEP_W constants in shared package c8_ctrl_pkg.
REQ-032 SHALL isolate the counter register, incrementer, source mux and wrap detect in one sub-module c8_cnt_dp; FSM and step counter stay in c8_seq_ctrl.

Verification
REQ-033 SHALL check LOAD_A with a_data_pad = 0x5A -> cnt_pad = 0x5A after the accept edge, done_pad pulse one cycle later, cmd_ready_pad low for that cycle.
REQ-034 SHALL check LOAD_B 0xFD then COUNT N = 4 -> cnt_pad 0xFE, 0xFF, 0x00, 0x01; wrap_pad single pulse after the 0xFF -> 0x00 step; done_pad 5 cycles after accept.
REQ-035 SHALL check COUNT N = 3 from 0x10 with halt_pad high for 2 cycles mid-run -> final 0x13; done_pad delayed by exactly 2 cycles.
REQ-036 SHALL check COUNT N = 0 -> cnt_pad unchanged; done_pad 1 cycle after accept; no wrap_pad.
REQ-037 SHALL check rst_n_pad low during COUNT N = 200 -> cnt_pad 0 and IDLE immediately, no done_pad; the next CLEAR completes normally.
REQ-038 SHALL check back-to-back valid commands -> second accepted on the cycle after DONE; none dropped or duplicated.
